// File: rtl/float_multiplier_param.sv
// Parameterised minifloat multiplier: e4m3-style or IEEE-style (bf16) formats.
// Uses a sequential shift-add significand multiply, then one normalise/round/pack cycle.
module float_multiplier_param #(
    parameter int EXP_W   = 4,
    parameter int MAN_W   = 3,
    parameter int HAS_INF = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   is_input_valid,
    output logic                   is_input_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   is_output_valid,
    input  logic                   is_output_ready
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int CNT_W  = $clog2(SIG_W + 1);
    localparam int EW     = EXP_W + 2;

    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic [MAN_W-1:0]    MAN_ONES = '1;
    localparam logic [MAN_W-1:0]    MAN_MAXF = {{(MAN_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0]    NAN_MAN  = (HAS_INF != 0) ? {1'b1, {(MAN_W-1){1'b0}}} : MAN_ONES;
    localparam logic signed [EW-1:0] EXP_MAX = {2'b00, EXP_ONES};
    localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);

    typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, y_q, y_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d, prod_q, prod_d;
    logic [SIG_W-1:0]    mplier_q, mplier_d;

    logic                sA, sB, resSign;
    logic [EXP_W-1:0]    eA, eB;
    logic [MAN_W-1:0]    mA, mB;
    logic [SIG_W-1:0]    sigA, sigB;

    assign sA   = a_q[W-1];
    assign sB   = b_q[W-1];
    assign eA   = a_q[W-2 -: EXP_W];
    assign eB   = b_q[W-2 -: EXP_W];
    assign mA   = a_q[MAN_W-1:0];
    assign mB   = b_q[MAN_W-1:0];
    assign sigA = {(eA != '0), mA};
    assign sigB = {(eB != '0), mB};
    assign resSign = sA ^ sB;

    assign is_input_ready  = (state_q == IDLE);
    assign is_output_valid = (state_q == DONE);
    assign y               = y_q;

    logic                aZero, bZero, aInf, bInf, aNaN, bNaN;
    logic [PROD_W-1:0]   normSig;
    logic [MAN_W-1:0]    mant;
    logic                guardBit, stickyBit, roundUp;
    logic [MAN_W:0]      mantR;
    logic signed [EW-1:0] expR;
    logic [W-1:0]        rndY;

    // Operand classification plus normalise, round-to-nearest-even and special-value packing.
    always_comb begin
        aZero = (eA == '0);
        bZero = (eB == '0);
        if (HAS_INF != 0) begin
            aInf = (eA == EXP_ONES) && (mA == '0);
            bInf = (eB == EXP_ONES) && (mB == '0);
            aNaN = (eA == EXP_ONES) && (mA != '0);
            bNaN = (eB == EXP_ONES) && (mB != '0);
        end else begin
            aInf = 1'b0;
            bInf = 1'b0;
            aNaN = (eA == EXP_ONES) && (mA == MAN_ONES);
            bNaN = (eB == EXP_ONES) && (mB == MAN_ONES);
        end

        normSig   = prod_q[PROD_W-1] ? prod_q : (prod_q << 1);
        mant      = normSig[PROD_W-2 -: MAN_W];
        guardBit  = normSig[MAN_W];
        stickyBit = |normSig[MAN_W-1:0];
        roundUp   = guardBit & (stickyBit | mant[0]);
        mantR     = {1'b0, mant} + {{MAN_W{1'b0}}, roundUp};
        expR      = EW'(eA) + EW'(eB) - BIAS_E + EW'(prod_q[PROD_W-1]) + EW'(mantR[MAN_W]);

        if (aNaN || bNaN || (aInf && bZero) || (bInf && aZero)) begin
            rndY = {1'b0, EXP_ONES, NAN_MAN};
        end else if (aInf || bInf) begin
            rndY = {resSign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (aZero || bZero || (expR <= 0)) begin
            rndY = {resSign, {(W-1){1'b0}}};
        end else if ((HAS_INF != 0) && (expR >= EXP_MAX)) begin
            rndY = {resSign, EXP_ONES, {MAN_W{1'b0}}};
        end else if ((HAS_INF == 0) &&
                     ((expR > EXP_MAX) || ((expR == EXP_MAX) && (mantR[MAN_W-1:0] == MAN_ONES)))) begin
            rndY = {resSign, EXP_ONES, MAN_MAXF};
        end else begin
            rndY = {resSign, expR[EXP_W-1:0], mantR[MAN_W-1:0]};
        end
    end

    // The first MUL cycle loads the hidden-bit significands; the next SIG_W cycles are shift-add steps.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        case (state_q)
            IDLE: begin
                if (is_input_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    mcand_d  = {{(PROD_W-SIG_W){1'b0}}, sigA};
                    mplier_d = sigB;
                    prod_d   = '0;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CNT_W'(SIG_W)) begin
                        cnt_d   = '0;
                        state_d = RND;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RND: begin
                y_d     = rndY;
                state_d = DONE;
            end
            DONE: begin
                if (is_output_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

endmodule
